// File: rtl/acc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : acc_pkg                                                      |
// | Description : Accelerator-interface shared types. Holds the memory request |
// |               type carried on the cmem request channel.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package acc_pkg;

    // READ encodes to 0 so an idle request channel reads as all-zero.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_req_type_e;

endpackage

`default_nettype wire

// File: rtl/fpu_ss_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : fpu_ss_pkg                                                   |
// | Description : Types shared by the FPU subsystem issue controller: the      |
// |               load/store FSM state encoding and the in-order tracking      |
// |               queue entry {rd_is_fp, rd_addr}.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package fpu_ss_pkg;

    // FP register address width; the tracking entry is sized from it, so the
    // controller's ADDR_W must match.
    localparam int unsigned FPR_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mem_fsm_e;

    typedef struct packed {
        logic                  rd_is_fp;
        logic [FPR_ADDR_W-1:0] rd_addr;
    } track_entry_t;

endpackage

`default_nettype wire

// File: rtl/fpu_ss_track_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : fpu_ss_track_fifo                                            |
// | Description : Depth-DEPTH synchronous FIFO with occupancy count, used to   |
// |               remember the destination of every in-flight FPU op in issue  |
// |               order. DEPTH must be a power of two so pointers wrap freely. |
// | Ports       : clk_i, rst_ni (async, active-low)                            |
// |               push_i/data_i  - enqueue                                     |
// |               pop_i/data_o   - dequeue / head entry                        |
// |               full_o, empty_o, cnt_o - occupancy                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpu_ss_track_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 6,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam int unsigned    c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_push;
    logic               w_pop;

    assign full_o  = (r_cnt == c_FULL_CNT);
    assign empty_o = (r_cnt == '0);
    assign cnt_o   = r_cnt;
    assign data_o  = r_mem[r_rptr];

    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while non-empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/fpu_ss_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : fpu_ss_issue_ctrl                                            |
// | Description : Pipelined FPU issue controller. Issues up to MAX_INFLIGHT    |
// |               FPU ops back-to-back, blocks RAW/WAW hazards with a per-FPR  |
// |               pending scoreboard, steers in-order results to the FPR file  |
// |               or the integer C-response channel, and sequences FP loads /  |
// |               stores on the cmem channels with a small FSM.                |
// | Ports       : clk_i, rst_ni (async, active-low)                            |
// |               pop_*         - instruction buffer head + decoded fields     |
// |               fpu_in/out_*  - FPU issue / result handshakes                |
// |               fpr_*         - FPR file write port                          |
// |               c_p_*         - integer C-response channel                   |
// |               cmem_q/p_*    - memory request / response channels           |
// |               inflight_cnt_o, idle_o - status                              |
// |               perf_stall_o, perf_retired_o - performance counters          |
// | Config      : `define FPU_SS_ISSUE_CTRL_PERF_EN builds the performance     |
// |               counters; otherwise both perf ports read 0.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpu_ss_issue_ctrl
    import fpu_ss_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned ADDR_W       = FPR_ADDR_W,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    pop_valid_i,
    output logic                    pop_ready_o,
    input  logic                    use_fpu_i,
    input  logic                    rd_is_fp_i,
    input  logic [ADDR_W-1:0]       rd_addr_i,
    input  logic [3*ADDR_W-1:0]     rs_addr_i,
    input  logic [2:0]              rs_used_i,
    input  logic                    csr_instr_i,
    input  logic                    is_load_i,
    input  logic                    is_store_i,
    output logic                    fpu_in_valid_o,
    input  logic                    fpu_in_ready_i,
    input  logic                    fpu_out_valid_i,
    output logic                    fpu_out_ready_o,
    output logic                    fpr_we_o,
    output logic [ADDR_W-1:0]       fpr_waddr_o,
    output logic                    c_p_valid_o,
    input  logic                    c_p_ready_i,
    output logic                    cmem_q_valid_o,
    input  logic                    cmem_q_ready_i,
    output acc_pkg::mem_req_type_e  cmem_q_req_type_o,
    output logic                    cmem_q_endoftransaction_o,
    input  logic                    cmem_p_valid_i,
    output logic                    cmem_p_ready_o,
    output logic [CNT_W-1:0]        inflight_cnt_o,
    output logic                    idle_o,
    output logic [31:0]             perf_stall_o,
    output logic [31:0]             perf_retired_o
);

    localparam int unsigned c_NUM_FPR = 1 << ADDR_W;

    logic [c_NUM_FPR-1:0] r_sb;
    logic [c_NUM_FPR-1:0] w_sb_next;
    mem_fsm_e             r_state;
    logic [ADDR_W-1:0]    r_mem_rd;
    logic                 r_mem_is_load;

    track_entry_t         w_push_entry;
    track_entry_t         w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [2:0]           w_rs_pend;
    logic                 w_hazard;
    logic                 w_fsm_idle;
    logic                 w_issue;
    logic                 w_head_fp;
    logic                 w_head_int;
    logic                 w_res_hs;
    logic                 w_fpu_fpr_wr;
    logic                 w_csr_valid;
    logic                 w_mem_start;
    logic                 w_mem_done;
    logic                 w_mem_wr;

    // ---------------- hazard detection ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rs_pend
        assign w_rs_pend[g] = rs_used_i[g] & r_sb[rs_addr_i[g*ADDR_W +: ADDR_W]];
    end

    assign w_hazard   = (|w_rs_pend) | (rd_is_fp_i & r_sb[rd_addr_i]);
    assign w_fsm_idle = (r_state == IDLE);

    // ---------------- FPU issue ----------------
    assign fpu_in_valid_o = pop_valid_i & use_fpu_i & ~w_full & ~w_hazard & w_fsm_idle;
    assign w_issue        = fpu_in_valid_o & fpu_in_ready_i;

    assign w_push_entry.rd_is_fp = rd_is_fp_i;
    assign w_push_entry.rd_addr  = rd_addr_i;

    fpu_ss_track_fifo #(
        .DEPTH  (MAX_INFLIGHT),
        .DATA_W ($bits(track_entry_t)),
        .CNT_W  (CNT_W)
    ) u_track_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_issue),
        .data_i  (w_push_entry),
        .pop_i   (w_res_hs),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .cnt_o   (inflight_cnt_o)
    );

    // ---------------- FPU completion steering ----------------
    // The head entry is only meaningful while the queue holds something.
    assign w_head_fp       = ~w_empty & w_head.rd_is_fp;
    assign w_head_int      = ~w_empty & ~w_head.rd_is_fp;
    assign fpu_out_ready_o = w_head_fp | (w_head_int & c_p_ready_i);
    assign w_res_hs        = fpu_out_valid_i & fpu_out_ready_o;
    assign w_fpu_fpr_wr    = fpu_out_valid_i & w_head_fp;

    // ---------------- CSR and memory dispatch ----------------
    // Both wait for an empty queue, so they never compete with FPU writeback.
    assign w_csr_valid = pop_valid_i & csr_instr_i & ~use_fpu_i & w_empty & w_fsm_idle;
    assign w_mem_start = pop_valid_i & ~use_fpu_i & ~csr_instr_i
                       & (is_load_i | is_store_i) & w_empty & w_fsm_idle;
    assign w_mem_done  = (r_state == RSP) & cmem_p_valid_i;
    assign w_mem_wr    = w_mem_done & r_mem_is_load;

    assign c_p_valid_o = (fpu_out_valid_i & w_head_int) | w_csr_valid;
    assign pop_ready_o = w_issue | (w_csr_valid & c_p_ready_i) | w_mem_done;

    assign fpr_we_o    = w_fpu_fpr_wr | w_mem_wr;
    assign fpr_waddr_o = w_mem_wr     ? r_mem_rd :
                         w_fpu_fpr_wr ? w_head.rd_addr : '0;

    assign cmem_q_valid_o            = (r_state == REQ);
    assign cmem_q_req_type_o         = ((r_state == REQ) && !r_mem_is_load) ? acc_pkg::WRITE
                                                                            : acc_pkg::READ;
    assign cmem_q_endoftransaction_o = cmem_q_valid_o & cmem_q_ready_i;
    assign cmem_p_ready_o            = 1'b1;

    assign idle_o = w_empty & w_fsm_idle;

    // ---------------- scoreboard ----------------
    // Clear before set: a same-cycle set targets a different register, since
    // a pending destination raises the hazard and blocks the issue.
    always_comb begin
        w_sb_next = r_sb;
        if (w_fpu_fpr_wr)          w_sb_next[w_head.rd_addr] = 1'b0;
        if (w_issue && rd_is_fp_i) w_sb_next[rd_addr_i]      = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_sb <= '0;
        else         r_sb <= w_sb_next;
    end

    // ---------------- load/store FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_mem_rd      <= '0;
            r_mem_is_load <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_mem_start) begin
                    r_state       <= REQ;
                    r_mem_rd      <= rd_addr_i;
                    r_mem_is_load <= is_load_i;
                end
                REQ:     if (cmem_q_ready_i) r_state <= RSP;
                RSP:     if (cmem_p_valid_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------- performance counters ----------------
`ifdef FPU_SS_ISSUE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_retired;
    logic        w_stall;

    assign w_stall = pop_valid_i & use_fpu_i & (w_hazard | w_full);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_stall   <= '0;
            r_perf_retired <= '0;
        end else begin
            if (w_stall && (r_perf_stall != '1))       r_perf_stall   <= r_perf_stall + 1'b1;
            if (pop_ready_o && (r_perf_retired != '1)) r_perf_retired <= r_perf_retired + 1'b1;
        end
    end

    assign perf_stall_o   = r_perf_stall;
    assign perf_retired_o = r_perf_retired;
`else
    assign perf_stall_o   = '0;
    assign perf_retired_o = '0;
`endif

    // Every instruction reaching this block is FPU, CSR, load or store.
    a_known_instr: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_valid_i |-> (use_fpu_i | csr_instr_i | is_load_i | is_store_i));

endmodule

`default_nettype wire

// File: tb/tb_fpu_ss_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_fpu_ss_issue_ctrl                                         |
// | Description : Random-program bench for fpu_ss_issue_ctrl. A driver feeds a |
// |               random instruction stream and plays FPU and memory; each     |
// |               presented instruction pushes its expected commit into a      |
// |               queue, and a monitor pops it when the DUT commits. Per-cycle |
// |               handshake expectations come from an abstract model (set of   |
// |               in-flight ops, memory phase). Ends with a reset during a     |
// |               load response.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fpu_ss_issue_ctrl;

    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned CNT_W        = 3;
    localparam int          N_INSTR      = 300;
    localparam int          TIMEOUT      = 20000;
    localparam int K_FPU = 0, K_CSR = 1, K_LOAD = 2, K_STORE = 3;
    localparam int EV_FPR = 0, EV_CP = 1, EV_ST = 2;

    logic clk = 1'b0;
    logic rst_ni;
    logic pop_valid_i, pop_ready_o, use_fpu_i, rd_is_fp_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [3*ADDR_W-1:0] rs_addr_i;
    logic [2:0] rs_used_i;
    logic csr_instr_i, is_load_i, is_store_i;
    logic fpu_in_valid_o, fpu_in_ready_i, fpu_out_valid_i, fpu_out_ready_o;
    logic fpr_we_o;
    logic [ADDR_W-1:0] fpr_waddr_o;
    logic c_p_valid_o, c_p_ready_i;
    logic cmem_q_valid_o, cmem_q_ready_i, cmem_q_endoftransaction_o;
    acc_pkg::mem_req_type_e cmem_q_req_type_o;
    logic cmem_p_valid_i, cmem_p_ready_o;
    logic [CNT_W-1:0] inflight_cnt_o;
    logic idle_o;
    logic [31:0] perf_stall_o, perf_retired_o;

    fpu_ss_issue_ctrl #(.MAX_INFLIGHT(MAX_INFLIGHT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .pop_valid_i(pop_valid_i), .pop_ready_o(pop_ready_o),
        .use_fpu_i(use_fpu_i), .rd_is_fp_i(rd_is_fp_i), .rd_addr_i(rd_addr_i),
        .rs_addr_i(rs_addr_i), .rs_used_i(rs_used_i), .csr_instr_i(csr_instr_i),
        .is_load_i(is_load_i), .is_store_i(is_store_i),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o),
        .c_p_valid_o(c_p_valid_o), .c_p_ready_i(c_p_ready_i),
        .cmem_q_valid_o(cmem_q_valid_o), .cmem_q_ready_i(cmem_q_ready_i),
        .cmem_q_req_type_o(cmem_q_req_type_o),
        .cmem_q_endoftransaction_o(cmem_q_endoftransaction_o),
        .cmem_p_valid_i(cmem_p_valid_i), .cmem_p_ready_o(cmem_p_ready_o),
        .inflight_cnt_o(inflight_cnt_o), .idle_o(idle_o),
        .perf_stall_o(perf_stall_o), .perf_retired_o(perf_retired_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  kind;
        logic                fp;
        logic [ADDR_W-1:0]   rd;
        logic [3*ADDR_W-1:0] rs;
        logic [2:0]          used;
    } instr_t;
    typedef struct { logic fp; logic [ADDR_W-1:0] rd; int rdy; } fop_t;
    typedef struct { int kind; logic [ADDR_W-1:0] addr; } ev_t;

    instr_t prog [N_INSTR];
    fop_t   fpu_q [$];   // ops accepted by the modelled FPU, oldest first
    ev_t    exp_q [$];   // expected commits in program order
    int     pc = 0, cyc = 0, vectors = 0, miscompares = 0;
    int     stall_model = 0, retired_model = 0, mem_rsp_at = 0;
    bit     run_en = 0, mreq = 0, mrsp = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic match_commit(input int kind, input logic [ADDR_W-1:0] addr, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected commit kind %0d, expected none (cycle %0d)", name, kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, 32'(kind), 32'(e.kind));
            if (e.kind == EV_FPR && kind == EV_FPR) chk({name, "_addr"}, 32'(addr), 32'(e.addr));
        end
    endtask

    // A source or destination collides with any op whose FP result is not yet written.
    function automatic bit model_hazard(input instr_t h);
        bit hz = 0;
        foreach (fpu_q[i]) begin
            if (fpu_q[i].fp) begin
                if (h.fp && h.rd == fpu_q[i].rd) hz = 1;
                for (int s = 0; s < 3; s++)
                    if (h.used[s] && h.rs[s*ADDR_W +: ADDR_W] == fpu_q[i].rd) hz = 1;
            end
        end
        return hz;
    endfunction

    // ---------------- monitor: per-cycle expectations and commit scoreboard ----------------
    initial begin
        instr_t hd;
        bit hv, haz, qe, e_in, e_pop, e_we, e_cp, mreq0, mrsp0;
        fop_t f;
        forever begin
            @(negedge clk);
            if (run_en) begin
                hv  = pop_valid_i && (pc < N_INSTR);
                hd  = prog[(pc < N_INSTR) ? pc : 0];
                haz = model_hazard(hd);
                qe  = (fpu_q.size() == 0);
                mreq0 = mreq;
                mrsp0 = mrsp;
                e_in  = hv && hd.kind == K_FPU && fpu_q.size() < MAX_INFLIGHT && !haz;
                e_cp  = (!qe && !fpu_q[0].fp && fpu_out_valid_i) || (hv && hd.kind == K_CSR && qe);
                e_we  = (!qe && fpu_q[0].fp && fpu_out_valid_i) || (mrsp0 && cmem_p_valid_i && hd.kind == K_LOAD);
                e_pop = (e_in && fpu_in_ready_i) || (hv && hd.kind == K_CSR && qe && c_p_ready_i)
                      || (mrsp0 && cmem_p_valid_i);

                chk("fpu_in_valid", 32'(fpu_in_valid_o), 32'(e_in));
                chk("fpu_out_ready", 32'(fpu_out_ready_o), 32'(!qe && (fpu_q[0].fp || c_p_ready_i)));
                chk("c_p_valid", 32'(c_p_valid_o), 32'(e_cp));
                chk("pop_ready", 32'(pop_ready_o), 32'(e_pop));
                chk("fpr_we", 32'(fpr_we_o), 32'(e_we));
                chk("cmem_q_valid", 32'(cmem_q_valid_o), 32'(mreq0));
                chk("cmem_eot", 32'(cmem_q_endoftransaction_o), 32'(mreq0 && cmem_q_ready_i));
                if (mreq0) chk("cmem_req_type", 32'(cmem_q_req_type_o), 32'(hd.kind == K_STORE));
                chk("inflight_cnt", 32'(inflight_cnt_o), 32'(fpu_q.size()));
                chk("idle", 32'(idle_o), 32'(qe && !mreq0 && !mrsp0));
                chk("cmem_p_ready", 32'(cmem_p_ready_o), 32'd1);
`ifndef FPU_SS_ISSUE_CTRL_PERF_EN
                chk("perf_off", perf_stall_o | perf_retired_o, 32'd0);
`endif
                if (fpr_we_o) match_commit(EV_FPR, fpr_waddr_o, "commit_fpr");
                if (c_p_valid_o && c_p_ready_i) match_commit(EV_CP, '0, "commit_cp");
                if (pop_ready_o && cmem_p_valid_i && !fpr_we_o) match_commit(EV_ST, '0, "commit_st");

                if (hv && hd.kind == K_FPU && (haz || fpu_q.size() >= MAX_INFLIGHT)) stall_model++;
                if (e_pop) retired_model++;

                // advance the model along the handshakes that complete at the next edge
                if (fpu_out_valid_i && fpu_out_ready_o && !qe) void'(fpu_q.pop_front());
                if (fpu_in_valid_o && fpu_in_ready_i) begin
                    f.fp  = hd.fp;
                    f.rd  = hd.rd;
                    f.rdy = cyc + 1 + $urandom_range(0, 3);
                    if (fpu_q.size() > 0 && fpu_q[$].rdy > f.rdy) f.rdy = fpu_q[$].rdy;
                    fpu_q.push_back(f);
                end
                if (mreq0 && cmem_q_valid_o && cmem_q_ready_i) begin
                    mreq = 0;
                    mrsp = 1;
                    mem_rsp_at = cyc + 1 + $urandom_range(0, 3);
                end
                if (mrsp0 && cmem_p_valid_i) mrsp = 0;
                else if (hv && (hd.kind == K_LOAD || hd.kind == K_STORE) && qe && !mreq0 && !mrsp0) mreq = 1;
                if (pop_valid_i && pop_ready_o) pc++;
            end
        end
    end

    task automatic drive_idle_inputs();
        pop_valid_i = 0; use_fpu_i = 0; rd_is_fp_i = 0; rd_addr_i = '0; rs_addr_i = '0;
        rs_used_i = '0; csr_instr_i = 0; is_load_i = 0; is_store_i = 0;
        fpu_in_ready_i = 0; fpu_out_valid_i = 0; c_p_ready_i = 0; cmem_q_ready_i = 0;
        cmem_p_valid_i = 0;
    endtask

    // ---------------- driver ----------------
    initial begin
        int pushed = 0;
        int r;
        int g;
        ev_t e;
        rst_ni = 0;
        drive_idle_inputs();

        for (int i = 0; i < N_INSTR; i++) begin
            r = $urandom_range(0, 99);
            prog[i].kind = (r < 70) ? K_FPU : (r < 80) ? K_CSR : (r < 90) ? K_LOAD : K_STORE;
            prog[i].fp   = (prog[i].kind == K_FPU) ? ($urandom_range(0, 3) != 0) : (prog[i].kind == K_LOAD);
            prog[i].rd   = ADDR_W'($urandom_range(0, 7));
            prog[i].rs   = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
                            ADDR_W'($urandom_range(0, 7))};
            prog[i].used = (prog[i].kind == K_FPU) ? 3'($urandom_range(0, 7)) : 3'b000;
        end

        repeat (3) @(posedge clk);
        #1 rst_ni = 1;
        @(negedge clk);
        chk("rst_pop_ready", 32'(pop_ready_o), 32'd0);
        chk("rst_fpu_in_valid", 32'(fpu_in_valid_o), 32'd0);
        chk("rst_fpu_out_ready", 32'(fpu_out_ready_o), 32'd0);
        chk("rst_fpr_we", 32'(fpr_we_o), 32'd0);
        chk("rst_c_p_valid", 32'(c_p_valid_o), 32'd0);
        chk("rst_cmem_q_valid", 32'(cmem_q_valid_o), 32'd0);
        chk("rst_cmem_p_ready", 32'(cmem_p_ready_o), 32'd1);
        chk("rst_inflight", 32'(inflight_cnt_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_perf", perf_stall_o | perf_retired_o, 32'd0);
        run_en = 1;

        while ((pc < N_INSTR || fpu_q.size() != 0 || mreq || mrsp) && cyc < TIMEOUT) begin
            @(posedge clk);
            #1;
            while (pushed <= pc && pushed < N_INSTR) begin
                e.kind = (prog[pushed].kind == K_STORE) ? EV_ST :
                         (prog[pushed].kind == K_CSR || !prog[pushed].fp) ? EV_CP : EV_FPR;
                e.addr = prog[pushed].rd;
                exp_q.push_back(e);
                pushed++;
            end
            if (pc < N_INSTR) begin
                pop_valid_i = 1;
                use_fpu_i   = (prog[pc].kind == K_FPU);
                csr_instr_i = (prog[pc].kind == K_CSR);
                is_load_i   = (prog[pc].kind == K_LOAD);
                is_store_i  = (prog[pc].kind == K_STORE);
                rd_is_fp_i  = prog[pc].fp;
                rd_addr_i   = prog[pc].rd;
                rs_addr_i   = prog[pc].rs;
                rs_used_i   = prog[pc].used;
            end else begin
                pop_valid_i = 0; use_fpu_i = 0; csr_instr_i = 0; is_load_i = 0; is_store_i = 0;
            end
            fpu_in_ready_i  = ($urandom_range(0, 3) != 0);
            c_p_ready_i     = ($urandom_range(0, 2) != 0);
            cmem_q_ready_i  = ($urandom_range(0, 1) != 0);
            fpu_out_valid_i = (fpu_q.size() > 0) && (cyc >= fpu_q[0].rdy);
            cmem_p_valid_i  = mrsp && (cyc >= mem_rsp_at);
        end
        @(negedge clk);
        run_en = 0;
        chk("program_done", 32'(pc), 32'(N_INSTR));
        chk("fpu_drained", 32'(fpu_q.size()), 32'd0);
        chk("commits_left", 32'(exp_q.size()), 32'd0);
`ifdef FPU_SS_ISSUE_CTRL_PERF_EN
        chk("perf_retired", perf_retired_o, 32'(retired_model));
        chk("perf_stall", perf_stall_o, 32'(stall_model));
`endif

        // reset while a load waits for its memory response
        @(posedge clk);
        #1;
        drive_idle_inputs();
        pop_valid_i = 1; is_load_i = 1; rd_is_fp_i = 1; rd_addr_i = 5'd7; cmem_q_ready_i = 1;
        g = 0;
        @(negedge clk);
        while (!cmem_q_valid_o && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("rsp_load_req", 32'(cmem_q_valid_o), 32'd1);
        @(posedge clk);
        #1;
        chk("rsp_load_busy", 32'(idle_o), 32'd0);
        rst_ni = 0;
        drive_idle_inputs();
        #1;
        chk("mid_rst_pop_ready", 32'(pop_ready_o), 32'd0);
        chk("mid_rst_fpr_we", 32'(fpr_we_o), 32'd0);
        chk("mid_rst_cmem_q_valid", 32'(cmem_q_valid_o), 32'd0);
        chk("mid_rst_inflight", 32'(inflight_cnt_o), 32'd0);
        chk("mid_rst_idle", 32'(idle_o), 32'd1);
        chk("mid_rst_cmem_p_ready", 32'(cmem_p_ready_o), 32'd1);
        chk("mid_rst_perf", perf_stall_o | perf_retired_o, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1;
        cmem_p_valid_i = 1;
        @(negedge clk);
        chk("post_rst_idle", 32'(idle_o), 32'd1);
        chk("post_rst_no_pop", 32'(pop_ready_o), 32'd0);
        chk("post_rst_no_we", 32'(fpr_we_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
